// File: rtl/sim_intf_pkg.sv
// Shared types and helpers for the multi-lane simulator interface checker.
package sim_intf_pkg;

  localparam int XLEN_DEF = 64;
  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [31:0] inst_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  typedef struct packed {
    logic       miss;
    logic [2:0] lane;
    xlen_t      pc_try;
    xlen_t      pc_factual;
    inst_t      inst;
  } chk_res_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? CNT_SAT : s[31:0];
  endfunction

endpackage

// File: rtl/sim_intf_fifo.sv
// Expected-record FIFO: one push per cycle, pops 0..RETIRE_W, exposes RETIRE_W head entries.
module sim_intf_fifo
  import sim_intf_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 8,
  parameter int RETIRE_W = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic [XLEN-1:0]                    push_pc,
  input  inst_t                              push_inst,
  input  logic [2:0]                         pop_n,
  output logic [$clog2(DEPTH):0]             count,
  output logic [RETIRE_W-1:0][XLEN-1:0]      head_pc,
  output inst_t [RETIRE_W-1:0]               head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem_pc   [DEPTH];
  inst_t           mem_inst [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= push_pc;
      mem_inst[wr_ptr] <= push_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
    end
  end

  // Head window wraps naturally because the index is AW bits wide.
  always_comb begin
    for (int i = 0; i < RETIRE_W; i++) begin
      logic [AW-1:0] idx;
      idx          = rd_ptr + AW'(i);
      head_pc[i]   = mem_pc[idx];
      head_inst[i] = mem_inst[idx];
    end
  end

endmodule

// File: rtl/sim_intf_mlane.sv
// Multi-lane commit checker: compares committed PCs against golden records from the reference model.
module sim_intf_mlane
  import sim_intf_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int RETIRE_W     = 2,
  parameter int DEPTH        = 8,
  parameter bit STOP_ON_MISS = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        exp_valid,
  output logic                        exp_ready,
  input  logic [XLEN-1:0]             exp_pc,
  input  logic [31:0]                 exp_inst,
  input  logic [RETIRE_W-1:0]         commit_valid,
  output logic                        commit_ready,
  input  logic [RETIRE_W*XLEN-1:0]    commit_pc,
  input  logic                        clr,
  output logic                        chk_valid,
  output logic                        chk_miss,
  output logic [$clog2(RETIRE_W):0]   chk_lane,
  output logic [XLEN-1:0]             chk_pc_try,
  output logic [XLEN-1:0]             chk_pc_factual,
  output logic [31:0]                 chk_inst,
  output logic [31:0]                 ok_cnt,
  output logic [31:0]                 miss_cnt,
  output logic                        halted,
  output logic                        err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = $clog2(RETIRE_W) + 1;

  logic [CW-1:0]                 count;
  logic [RETIRE_W-1:0][XLEN-1:0] head_pc;
  inst_t [RETIRE_W-1:0]          head_inst;
  state_e                        state;
  chk_res_t                      res;

  logic [2:0]          n_valid, n_miss, sel_lane;
  logic                thermo, any_valid, any_miss, accept, push;
  logic [RETIRE_W-1:0] miss_vec;
  logic [XLEN-1:0]     sel_try, sel_fact;
  inst_t               sel_inst;

  sim_intf_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .RETIRE_W(RETIRE_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_pc   (exp_pc),
    .push_inst (exp_inst),
    .pop_n     (accept ? n_valid : 3'd0),
    .count     (count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  // A beat is only taken whole: every valid lane must have a matching FIFO entry.
  always_comb begin
    n_valid      = popcount4(4'(commit_valid));
    thermo       = ((commit_valid & (commit_valid + RETIRE_W'(1))) == '0);
    any_valid    = |commit_valid;
    exp_ready    = (count < CW'(DEPTH));
    commit_ready = (state == RUN) && (count != '0) && (32'(count) >= 32'(n_valid));
    accept       = commit_ready && any_valid && thermo;
    push         = exp_valid && exp_ready;
    for (int i = 0; i < RETIRE_W; i++)
      miss_vec[i] = commit_valid[i] && (commit_pc[i*XLEN +: XLEN] != head_pc[i]);
    any_miss = |miss_vec;
    n_miss   = popcount4(4'(miss_vec));
    sel_lane = n_valid - 3'd1;
    for (int i = RETIRE_W-1; i >= 0; i--)
      if (miss_vec[i]) sel_lane = 3'(i);
    sel_try  = '0;
    sel_fact = '0;
    sel_inst = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (3'(i) == sel_lane) begin
        sel_try  = commit_pc[i*XLEN +: XLEN];
        sel_fact = head_pc[i];
        sel_inst = head_inst[i];
      end
    end
  end

  // Result register, statistics, sticky error and RUN/HALT control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      res       <= '0;
      chk_valid <= 1'b0;
      ok_cnt    <= '0;
      miss_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      chk_valid <= accept;
      if (accept) begin
        res.miss       <= any_miss;
        res.lane       <= sel_lane;
        res.pc_try     <= xlen_t'(sel_try);
        res.pc_factual <= xlen_t'(sel_fact);
        res.inst       <= sel_inst;
        ok_cnt         <= sat_add(ok_cnt, n_valid - n_miss);
        miss_cnt       <= sat_add(miss_cnt, n_miss);
      end
      if (any_valid && !thermo) err <= 1'b1;
      else if (clr)             err <= 1'b0;
      case (state)
        RUN:  if (accept && any_miss && STOP_ON_MISS) state <= HALT;
        HALT: if (clr) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  if (LW < 3) begin : g_lane_pad
    logic unused_lane;
    assign unused_lane = ^res.lane[2:LW];
  end

  assign chk_miss       = res.miss;
  assign chk_lane       = res.lane[LW-1:0];
  assign chk_pc_try     = res.pc_try[XLEN-1:0];
  assign chk_pc_factual = res.pc_factual[XLEN-1:0];
  assign chk_inst       = res.inst;
  assign halted         = (state == HALT);

endmodule

// File: tb/tb_sim_intf_mlane.sv
// Self-checking bench: directed vector table, corner sequences, and a queue-model random run.
module tb_sim_intf_mlane;

  localparam int XLEN  = 64;
  localparam int RW    = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             exp_valid;
  logic [XLEN-1:0]  exp_pc;
  logic [31:0]      exp_inst;
  logic [RW-1:0]    commit_valid;
  logic [RW*XLEN-1:0] commit_pc;
  logic             clr;

  logic a_exp_ready, a_commit_ready, a_chk_valid, a_chk_miss, a_halted, a_err;
  logic [1:0] a_chk_lane;
  logic [XLEN-1:0] a_chk_pc_try, a_chk_pc_factual;
  logic [31:0] a_chk_inst, a_ok_cnt, a_miss_cnt;

  logic b_exp_ready, b_commit_ready, b_chk_valid, b_chk_miss, b_halted, b_err;
  logic [1:0] b_chk_lane;
  logic [XLEN-1:0] b_chk_pc_try, b_chk_pc_factual;
  logic [31:0] b_chk_inst, b_ok_cnt, b_miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_intf_mlane #(.XLEN(XLEN), .RETIRE_W(RW), .DEPTH(DEPTH), .STOP_ON_MISS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_ready(a_exp_ready),
    .exp_pc(exp_pc), .exp_inst(exp_inst), .commit_valid(commit_valid),
    .commit_ready(a_commit_ready), .commit_pc(commit_pc), .clr(clr),
    .chk_valid(a_chk_valid), .chk_miss(a_chk_miss), .chk_lane(a_chk_lane),
    .chk_pc_try(a_chk_pc_try), .chk_pc_factual(a_chk_pc_factual), .chk_inst(a_chk_inst),
    .ok_cnt(a_ok_cnt), .miss_cnt(a_miss_cnt), .halted(a_halted), .err(a_err)
  );

  sim_intf_mlane #(.XLEN(XLEN), .RETIRE_W(RW), .DEPTH(DEPTH), .STOP_ON_MISS(1'b0)) dut_nostop (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_ready(b_exp_ready),
    .exp_pc(exp_pc), .exp_inst(exp_inst), .commit_valid(commit_valid),
    .commit_ready(b_commit_ready), .commit_pc(commit_pc), .clr(clr),
    .chk_valid(b_chk_valid), .chk_miss(b_chk_miss), .chk_lane(b_chk_lane),
    .chk_pc_try(b_chk_pc_try), .chk_pc_factual(b_chk_pc_factual), .chk_inst(b_chk_inst),
    .ok_cnt(b_ok_cnt), .miss_cnt(b_miss_cnt), .halted(b_halted), .err(b_err)
  );

  typedef struct {
    logic        ev;
    logic [63:0] epc;
    logic [31:0] einst;
    logic [1:0]  cv;
    logic [63:0] cp0;
    logic [63:0] cp1;
    logic        clr;
    logic        erdy;
    logic        crdy;
    logic        cvld;
    logic        cmiss;
    logic [1:0]  lane;
    logic [63:0] pctry;
    logic [63:0] pcfact;
    logic [31:0] inst;
    logic [31:0] okc;
    logic [31:0] missc;
    logic        hlt;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } rec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [63:0] epc, input logic [31:0] einst,
                               input logic [1:0] cv, input logic [63:0] c0, input logic [63:0] c1,
                               input logic cl);
    exp_valid    = ev;
    exp_pc       = epc;
    exp_inst     = einst;
    commit_valid = cv;
    commit_pc    = {c1, c0};
    clr          = cl;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 64'h0, 32'h0, 2'b00, 64'h0, 64'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 32'h0, 2'b00, 64'h0, 64'h0, 1'b0);
  endtask

  vec_t vecs[13];

  rec_t        q[$];
  logic        m_cv, m_miss, m_halt, m_err;
  logic [1:0]  m_lane;
  logic [63:0] m_try, m_fact;
  logic [31:0] m_inst, m_ok, m_missc;

  initial begin
    vecs[0]  = '{1'b1, 64'h0,    32'h13,  2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 64'h1000, 32'h93,  2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 64'h1004, 32'h113, 2'b01, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1,
                 1'b1, 1'b0, 2'd0, 64'h0, 64'h0, 32'h13, 32'd1, 32'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 64'h0, 32'h0, 2'b11, 64'h1000, 64'h1004, 1'b0, 1'b1, 1'b1,
                 1'b1, 1'b0, 2'd1, 64'h1004, 64'h1004, 32'h113, 32'd3, 32'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 64'h1008, 32'h193, 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd3, 32'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 64'h100C, 32'h213, 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd3, 32'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 64'h0, 32'h0, 2'b11, 64'hAAAA1008, 64'h100C, 1'b0, 1'b1, 1'b1,
                 1'b1, 1'b1, 2'd0, 64'hAAAA1008, 64'h1008, 32'h193, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 64'h1010, 32'h293, 2'b01, 64'h1010, 64'h0, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd4, 32'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 64'h0, 32'h0, 2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd4, 32'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 64'h0, 32'h0, 2'b10, 64'h0, 64'h1010, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd4, 32'd1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 64'h0, 32'h0, 2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd4, 32'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 64'h0, 32'h0, 2'b01, 64'h1010, 64'h0, 1'b0, 1'b1, 1'b1,
                 1'b1, 1'b0, 2'd0, 64'h1010, 64'h1010, 32'h293, 32'd5, 32'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 64'h0, 32'h0, 2'b01, 64'h5555, 64'h0, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 32'h0, 32'd5, 32'd1, 1'b0, 1'b0};

    // Reset values while rst_n is held low
    applyStimulus(1'b0, 64'h0, 32'h0, 2'b00, 64'h0, 64'h0, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("reset_exp_ready", 64'(a_exp_ready), 64'd1);
    checkOutput("reset_commit_ready", 64'(a_commit_ready), 64'd0);
    checkOutput("reset_chk_valid", 64'(a_chk_valid), 64'd0);
    checkOutput("reset_ok_cnt", 64'(a_ok_cnt), 64'd0);
    doReset();

    // Directed vector table
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].ev, vecs[v].epc, vecs[v].einst, vecs[v].cv, vecs[v].cp0,
                    vecs[v].cp1, vecs[v].clr);
      #1;
      checkOutput($sformatf("v%0d_exp_ready", v), 64'(a_exp_ready), 64'(vecs[v].erdy));
      checkOutput($sformatf("v%0d_commit_ready", v), 64'(a_commit_ready), 64'(vecs[v].crdy));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_chk_valid", v), 64'(a_chk_valid), 64'(vecs[v].cvld));
      if (vecs[v].cvld) begin
        checkOutput($sformatf("v%0d_chk_miss", v), 64'(a_chk_miss), 64'(vecs[v].cmiss));
        checkOutput($sformatf("v%0d_chk_lane", v), 64'(a_chk_lane), 64'(vecs[v].lane));
        checkOutput($sformatf("v%0d_chk_pc_try", v), a_chk_pc_try, vecs[v].pctry);
        checkOutput($sformatf("v%0d_chk_pc_factual", v), a_chk_pc_factual, vecs[v].pcfact);
        checkOutput($sformatf("v%0d_chk_inst", v), 64'(a_chk_inst), 64'(vecs[v].inst));
      end
      checkOutput($sformatf("v%0d_ok_cnt", v), 64'(a_ok_cnt), 64'(vecs[v].okc));
      checkOutput($sformatf("v%0d_miss_cnt", v), 64'(a_miss_cnt), 64'(vecs[v].missc));
      checkOutput($sformatf("v%0d_halted", v), 64'(a_halted), 64'(vecs[v].hlt));
      checkOutput($sformatf("v%0d_err", v), 64'(a_err), 64'(vecs[v].err));
    end
    idleCycle();

    // Fill to DEPTH, then pop two while pushing: push must be refused
    doReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 64'(i * 4), 32'(i), 2'b00, 64'h0, 64'h0, 1'b0);
      #1;
      checkOutput($sformatf("fill%0d_exp_ready", i), 64'(a_exp_ready), (i < DEPTH) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    applyStimulus(1'b1, 64'h900, 32'h0, 2'b11, 64'h0, 64'h4, 1'b0);
    #1;
    checkOutput("full_pop_exp_ready", 64'(a_exp_ready), 64'd0);
    checkOutput("full_pop_commit_ready", 64'(a_commit_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("full_pop_chk_pc_factual", a_chk_pc_factual, 64'h4);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, 64'h0, 32'h0, 2'b11, 64'(k * 8), 64'(k * 8 + 4), 1'b0);
      #1;
      checkOutput($sformatf("drain%0d_commit_ready", k), 64'(a_commit_ready), 64'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("drain%0d_chk_pc_factual", k), a_chk_pc_factual, 64'(k * 8 + 4));
      checkOutput($sformatf("drain%0d_chk_miss", k), 64'(a_chk_miss), 64'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 32'h0, 2'b01, 64'h900, 64'h0, 1'b0);
    #1;
    checkOutput("drained_commit_ready", 64'(a_commit_ready), 64'd0);
    checkOutput("drained_ok_cnt", 64'(a_ok_cnt), 64'd8);
    idleCycle();

    // Count-and-continue instance
    doReset();
    @(negedge clk); applyStimulus(1'b1, 64'h1010, 32'h1, 2'b00, 64'h0, 64'h0, 1'b0);
    @(negedge clk); applyStimulus(1'b1, 64'h1014, 32'h2, 2'b00, 64'h0, 64'h0, 1'b0);
    @(negedge clk); applyStimulus(1'b0, 64'h0, 32'h0, 2'b11, 64'h1010, 64'hDDDD1014, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("nostop_chk_valid", 64'(b_chk_valid), 64'd1);
    checkOutput("nostop_chk_miss", 64'(b_chk_miss), 64'd1);
    checkOutput("nostop_chk_lane", 64'(b_chk_lane), 64'd1);
    checkOutput("nostop_chk_pc_try", b_chk_pc_try, 64'hDDDD1014);
    checkOutput("nostop_chk_pc_factual", b_chk_pc_factual, 64'h1014);
    checkOutput("nostop_chk_inst", 64'(b_chk_inst), 64'h2);
    checkOutput("nostop_ok_cnt", 64'(b_ok_cnt), 64'd1);
    checkOutput("nostop_miss_cnt", 64'(b_miss_cnt), 64'd1);
    checkOutput("nostop_halted", 64'(b_halted), 64'd0);
    checkOutput("stop_halted", 64'(a_halted), 64'd1);
    @(negedge clk); applyStimulus(1'b1, 64'h1018, 32'h3, 2'b00, 64'h0, 64'h0, 1'b0);
    @(negedge clk); applyStimulus(1'b0, 64'h0, 32'h0, 2'b01, 64'h1018, 64'h0, 1'b0);
    #1;
    checkOutput("nostop_commit_ready", 64'(b_commit_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("nostop_ok_cnt2", 64'(b_ok_cnt), 64'd2);
    checkOutput("nostop_chk_miss2", 64'(b_chk_miss), 64'd0);
    idleCycle();

    // Asynchronous reset with 5 entries queued while halted
    doReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 64'(i * 4), 32'(i), 2'b00, 64'h0, 64'h0, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 64'h0, 32'h0, 2'b01, 64'hBAD0, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("prerst_halted", 64'(a_halted), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_exp_ready", 64'(a_exp_ready), 64'd1);
    checkOutput("midrst_commit_ready", 64'(a_commit_ready), 64'd0);
    checkOutput("midrst_chk_valid", 64'(a_chk_valid), 64'd0);
    checkOutput("midrst_chk_miss", 64'(a_chk_miss), 64'd0);
    checkOutput("midrst_chk_pc_try", a_chk_pc_try, 64'h0);
    checkOutput("midrst_chk_pc_factual", a_chk_pc_factual, 64'h0);
    checkOutput("midrst_chk_inst", 64'(a_chk_inst), 64'h0);
    checkOutput("midrst_ok_cnt", 64'(a_ok_cnt), 64'd0);
    checkOutput("midrst_miss_cnt", 64'(a_miss_cnt), 64'd0);
    checkOutput("midrst_halted", 64'(a_halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 64'h0, 32'h0, 2'b01, 64'h0, 64'h0, 1'b0);
    #1;
    checkOutput("postrst_commit_ready", 64'(a_commit_ready), 64'd0);
    idleCycle();

    // Randomized run against a queue-based reference model
    doReset();
    q.delete();
    m_cv = 1'b0; m_miss = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_lane = 2'd0;
    m_try = 64'h0; m_fact = 64'h0; m_inst = 32'h0; m_ok = 32'd0; m_missc = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        ev, cl, thermo, gap, acc, m_er, m_cr, old_halt;
      logic [63:0] epc;
      logic [31:0] einst;
      logic [1:0]  cv;
      logic [63:0] lp [RW];
      int          r, n, nm, first, sel;
      @(negedge clk);
      checkOutput("rnd_chk_valid", 64'(a_chk_valid), 64'(m_cv));
      if (m_cv) begin
        checkOutput("rnd_chk_miss", 64'(a_chk_miss), 64'(m_miss));
        checkOutput("rnd_chk_lane", 64'(a_chk_lane), 64'(m_lane));
        checkOutput("rnd_chk_pc_try", a_chk_pc_try, m_try);
        checkOutput("rnd_chk_pc_factual", a_chk_pc_factual, m_fact);
        checkOutput("rnd_chk_inst", 64'(a_chk_inst), 64'(m_inst));
      end
      checkOutput("rnd_ok_cnt", 64'(a_ok_cnt), 64'(m_ok));
      checkOutput("rnd_miss_cnt", 64'(a_miss_cnt), 64'(m_missc));
      checkOutput("rnd_halted", 64'(a_halted), 64'(m_halt));
      checkOutput("rnd_err", 64'(a_err), 64'(m_err));

      ev    = ($urandom_range(0, 9) < 6);
      epc   = {32'h0, $urandom};
      einst = $urandom;
      r     = $urandom_range(0, 9);
      cv    = (r == 0) ? 2'b10 : (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'b11;
      for (int i = 0; i < RW; i++)
        lp[i] = (i < q.size() && $urandom_range(0, 7) != 0) ? q[i].pc : {32'hDEAD, $urandom};
      cl = ($urandom_range(0, 14) == 0);
      applyStimulus(ev, epc, einst, cv, lp[0], lp[1], cl);
      #1;
      n = 0; thermo = 1'b1; gap = 1'b0;
      for (int i = 0; i < RW; i++) begin
        if (cv[i]) begin
          n++;
          if (gap) thermo = 1'b0;
        end else begin
          gap = 1'b1;
        end
      end
      m_er = (q.size() < DEPTH);
      m_cr = !m_halt && (q.size() > 0) && (q.size() >= n);
      checkOutput("rnd_exp_ready", 64'(a_exp_ready), 64'(m_er));
      checkOutput("rnd_commit_ready", 64'(a_commit_ready), 64'(m_cr));

      acc      = m_cr && (n > 0) && thermo;
      old_halt = m_halt;
      m_cv     = acc;
      if (acc) begin
        nm = 0; first = -1;
        for (int i = 0; i < n; i++) begin
          if (lp[i] != q[i].pc) begin
            nm++;
            if (first < 0) first = i;
          end
        end
        sel     = (first >= 0) ? first : n - 1;
        m_miss  = (nm > 0);
        m_lane  = 2'(sel);
        m_try   = lp[sel];
        m_fact  = q[sel].pc;
        m_inst  = q[sel].inst;
        m_ok    = m_ok + 32'(n - nm);
        m_missc = m_missc + 32'(nm);
        for (int i = 0; i < n; i++) void'(q.pop_front());
      end
      if (old_halt && cl) m_halt = 1'b0;
      if (acc && nm > 0) m_halt = 1'b1;
      if (cv != 2'b00 && !thermo) m_err = 1'b1;
      else if (cl)                m_err = 1'b0;
      if (ev && m_er) q.push_back('{epc, einst});
    end
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
